// File: rtl/upcounter_dataflow_pkg.sv
// -----------------------------------------------------------------------------
// upcounter_dataflow_pkg
//   Shared constants for the dataflow up-counter and its incrementer.
//
//   DEFAULT_COUNTER_WIDTH : default counter width used by blocks that reuse it.
//   MIN_COUNTER_WIDTH     : smallest supported width.
//   MAX_COUNTER_WIDTH     : largest supported width.
// -----------------------------------------------------------------------------
package upcounter_dataflow_pkg;

  localparam int DEFAULT_COUNTER_WIDTH = 3;
  localparam int MIN_COUNTER_WIDTH     = 1;
  localparam int MAX_COUNTER_WIDTH     = 16;

endpackage : upcounter_dataflow_pkg

// File: rtl/upcounter_dataflow_incr.sv
// -----------------------------------------------------------------------------
// incr_dataflow
//   Pure dataflow incrementer: y = a + 1 (mod 2^WIDTH), built from an explicit
//   ripple carry chain so that each bit is a single toggle equation.
//
//   Ports:
//     a    : input  [WIDTH-1:0]  value to increment
//     y    : output [WIDTH-1:0]  a + 1 modulo 2^WIDTH
//     cout : output              carry out of the top bit (== &a)
// -----------------------------------------------------------------------------
module incr_dataflow
  import upcounter_dataflow_pkg::*;
#(
  parameter int WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  // w_carry[i] is the AND of a[i-1:0]; w_carry[0] is the constant 1 that
  // makes bit 0 toggle unconditionally.
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign w_carry[gi+1] = w_carry[gi] & a[gi];
    assign y[gi]         = a[gi] ^ w_carry[gi];
  end

  // The carry out of the full chain is high exactly when a is all-ones.
  assign cout = w_carry[WIDTH];

endmodule : incr_dataflow

// File: rtl/upcounter_dataflow.sv
// -----------------------------------------------------------------------------
// upcounter_dataflow
//   Free-running WIDTH-bit binary up-counter. The state register is the only
//   sequential element; next-state logic is the dataflow incrementer.
//
//   Parameters:
//     WIDTH       : counter width, 1..16
//     RESET_VALUE : value loaded during reset (truncated to WIDTH bits)
//
//   Ports:
//     clk   : input          rising-edge clock
//     rst   : input          synchronous reset, active low
//     count : output [W-1:0] current counter value (straight from the register)
//     tc    : output         terminal count, high while count is all-ones
// -----------------------------------------------------------------------------
module upcounter_dataflow
  import upcounter_dataflow_pkg::*;
#(
  parameter int          WIDTH       = DEFAULT_COUNTER_WIDTH,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LP_RESET_VALUE = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             w_all_ones;

  incr_dataflow #(
    .WIDTH (WIDTH)
  ) u_incr (
    .a    (r_count),
    .y    (w_count_next),
    .cout (w_all_ones)
  );

  // Reset takes priority over counting, including at the all-ones value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= LP_RESET_VALUE;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;
  // The incrementer carry out is exactly the all-ones detect of count.
  assign tc    = w_all_ones;

endmodule : upcounter_dataflow

// File: tb/tb_upcounter_dataflow.sv
// -----------------------------------------------------------------------------
// tb_upcounter_dataflow
//   Directed bench for upcounter_dataflow. Three instances share one clock:
//     u_dut3  : WIDTH=3, RESET_VALUE=0
//     u_dutr3 : WIDTH=3, RESET_VALUE=3
//     u_dut4  : WIDTH=4, RESET_VALUE=0
//   Each has its own reset so scenarios can be aimed at one instance.
// -----------------------------------------------------------------------------
module tb_upcounter_dataflow;

  logic       clk;
  logic       rst;
  logic       rst_r3;
  logic       rst_w4;
  logic [2:0] count3;
  logic       tc3;
  logic [2:0] count_r3;
  logic       tc_r3;
  logic [3:0] count4;
  logic       tc4;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected values from the bench's own reference counters.
  int e3  = 0;
  int er3 = 0;
  int e4  = 0;

  upcounter_dataflow #(.WIDTH(3), .RESET_VALUE(32'd0)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .count (count3),
    .tc    (tc3)
  );

  upcounter_dataflow #(.WIDTH(3), .RESET_VALUE(32'd3)) u_dutr3 (
    .clk   (clk),
    .rst   (rst_r3),
    .count (count_r3),
    .tc    (tc_r3)
  );

  upcounter_dataflow #(.WIDTH(4), .RESET_VALUE(32'd0)) u_dut4 (
    .clk   (clk),
    .rst   (rst_w4),
    .count (count4),
    .tc    (tc4)
  );

  // 100-unit period, rising edges at 50, 150, 250, ...
  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, update the reference counters from the reset
  // levels seen at that edge, then check every instance at the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    e3  = rst    ? (e3 + 1) % 8   : 0;
    er3 = rst_r3 ? (er3 + 1) % 8  : 3;
    e4  = rst_w4 ? (e4 + 1) % 16  : 0;
    @(negedge clk);
    chk({tag, "/count3"},  16'(count3),   16'(e3));
    chk({tag, "/tc3"},     16'(tc3),      16'(e3 == 7));
    chk({tag, "/countr3"}, 16'(count_r3), 16'(er3));
    chk({tag, "/tcr3"},    16'(tc_r3),    16'(er3 == 7));
    chk({tag, "/count4"},  16'(count4),   16'(e4));
    chk({tag, "/tc4"},     16'(tc4),      16'(e4 == 15));
    $display("step %-10s count3=%0d tc3=%0b count_r3=%0d tc_r3=%0b count4=%0d tc4=%0b",
             tag, count3, tc3, count_r3, tc_r3, count4, tc4);
  endtask

  initial begin
    int  v;
    bit  found;

    rst    = 1'b0;
    rst_r3 = 1'b0;
    rst_w4 = 1'b0;

    // Reset hold for two edges.
    step("rst_hold1");
    chk("rst_hold1_count", 16'(count3), 16'd0);
    chk("rst_hold1_tc",    16'(tc3),    16'd0);
    chk("rst_hold1_r3",    16'(count_r3), 16'd3);
    step("rst_hold2");
    chk("rst_hold2_count", 16'(count3), 16'd0);
    chk("rst_hold2_tc",    16'(tc3),    16'd0);

    // Release and count 1..7.
    rst    = 1'b1;
    rst_r3 = 1'b1;
    rst_w4 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step("count");
      chk("count_seq", 16'(count3), 16'(k));
      chk("count_tc",  16'(tc3),    (k == 7) ? 16'd1 : 16'd0);
    end

    // Wrap 7 -> 0.
    step("wrap");
    chk("wrap_count", 16'(count3), 16'd0);
    chk("wrap_tc",    16'(tc3),    16'd0);

    // 20-cycle run, period 8.
    for (int k = 1; k <= 20; k++) begin
      step("run20");
      chk("run20_seq", 16'(count3), 16'(k % 8));
    end

    // Reset mid-operation at count==5.
    step("to5");
    chk("mid_pre", 16'(count3), 16'd5);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("mid_hold");
      chk("mid_hold_count", 16'(count3), 16'd0);
    end
    rst = 1'b1;
    step("mid_rel");
    chk("mid_rel_count", 16'(count3), 16'd1);

    // Reset exactly at terminal count (RESET_VALUE=0 instance).
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (count3 == 3'd7) found = 1'b1;
      else step("seek7");
    end
    chk("seek7_found", 16'(found), 16'd1);
    chk("tc_at7", 16'(tc3), 16'd1);
    rst = 1'b0;
    step("rst_at7");
    chk("rst_at7_count", 16'(count3), 16'd0);
    chk("rst_at7_tc",    16'(tc3),    16'd0);
    rst = 1'b1;

    // Reset exactly at terminal count (RESET_VALUE=3 instance).
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (count_r3 == 3'd7) found = 1'b1;
      else step("seek7r3");
    end
    chk("seek7r3_found", 16'(found), 16'd1);
    rst_r3 = 1'b0;
    step("rst_at7r3");
    chk("rst_at7r3_count", 16'(count_r3), 16'd3);
    chk("rst_at7r3_tc",    16'(tc_r3),    16'd0);
    rst_r3 = 1'b1;
    step("rel_r3");
    chk("rel_r3_count", 16'(count_r3), 16'd4);

    // Reset glitch strictly between edges has no effect.
    v = int'(count3);
    #20 rst = 1'b0;
    #20 rst = 1'b1;
    step("glitch");
    chk("glitch_count", 16'(count3), 16'((v + 1) % 8));

    // WIDTH=4: reach 15 with tc high, then wrap to 0.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (count4 == 4'd15) found = 1'b1;
      else step("seek15");
    end
    chk("seek15_found", 16'(found), 16'd1);
    chk("w4_tc_at15",   16'(tc4),   16'd1);
    step("w4_wrap");
    chk("w4_wrap_count", 16'(count4), 16'd0);
    chk("w4_wrap_tc",    16'(tc4),    16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_upcounter_dataflow
